// File: rtl/tis_pkg.sv
// Shared TIS100 definitions used by node port logic, channels and the mesh top.
package tis_pkg;

  localparam int unsigned TIS_WORD_W  = 8;
  localparam int unsigned TIS_STALL_W = 16;

  typedef logic [TIS_WORD_W-1:0] tis_word_t;

endpackage

// File: rtl/tis_chan_stats.sv
// Saturating writer-stall counter for a TIS100 port channel.
// Counts cycles in which stall_evt is high; holds at all-ones instead of wrapping.
module tis_chan_stats
  import tis_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   stall_evt,
  output logic [TIS_STALL_W-1:0] stall_cnt
);

  // Saturating count; flush clears it alongside the channel contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (stall_evt && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tis_port_channel.sv
// Blocking point-to-point link between two TIS100 nodes: a DEPTH-entry
// circular buffer with valid/ready on both sides and no bypass path.
// Optional writer-stall statistics are built when TIS_CHAN_STATS_EN is defined;
// otherwise stall_cnt reads zero and no counter exists.
module tis_port_channel
  import tis_pkg::*;
#(
  parameter int unsigned WIDTH = TIS_WORD_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_valid,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_ready,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [TIS_STALL_W-1:0]     stall_cnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [PW-1:0] LASTPTR = PW'(DEPTH-1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  // Handshake flags come from registered occupancy only; flush suppresses both.
  always_comb begin
    wr_ready = (count != FULL);
    rd_valid = (count != '0);
    push     = wr_valid && wr_ready && !flush;
    pop      = rd_valid && rd_ready && !flush;
  end

  assign rd_data = mem[rdPtr];
  assign level   = count;

  // Pointer and occupancy update; explicit wrap keeps DEPTH=1 pointers at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= (wrPtr == LASTPTR) ? '0 : wrPtr + 1'b1;
      if (pop)  rdPtr <= (rdPtr == LASTPTR) ? '0 : rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage; cleared on reset so the head reads zero, untouched by flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wrPtr] <= wr_data;
    end
  end

`ifdef TIS_CHAN_STATS_EN
  logic stallEvt;
  assign stallEvt = wr_valid && !wr_ready;

  tis_chan_stats uStats (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .stall_evt (stallEvt),
    .stall_cnt (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_tis_port_channel.sv
// Directed self-checking bench for tis_port_channel at DEPTH 2, 4 and 1.
module tb_tis_port_channel;
  import tis_pkg::*;

`ifdef TIS_CHAN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic reset;

  // DEPTH=2 instance
  logic aFlush, aWv, aWr, aRv, aRr;
  logic [7:0] aWd, aRd;
  logic [1:0] aLvl;
  logic [15:0] aStall;
  // DEPTH=4 instance
  logic bFlush, bWv, bWr, bRv, bRr;
  logic [7:0] bWd, bRd;
  logic [2:0] bLvl;
  logic [15:0] bStall;
  // DEPTH=1 instance
  logic cFlush, cWv, cWr, cRv, cRr;
  logic [7:0] cWd, cRd;
  logic [0:0] cLvl;
  logic [15:0] cStall;

  int total = 0;
  int bad   = 0;

  tis_port_channel #(.WIDTH(8), .DEPTH(2)) dutA (
    .clk(clk), .reset(reset), .flush(aFlush), .wr_valid(aWv), .wr_data(aWd),
    .wr_ready(aWr), .rd_valid(aRv), .rd_data(aRd), .rd_ready(aRr),
    .level(aLvl), .stall_cnt(aStall));

  tis_port_channel #(.WIDTH(8), .DEPTH(4)) dutB (
    .clk(clk), .reset(reset), .flush(bFlush), .wr_valid(bWv), .wr_data(bWd),
    .wr_ready(bWr), .rd_valid(bRv), .rd_data(bRd), .rd_ready(bRr),
    .level(bLvl), .stall_cnt(bStall));

  tis_port_channel #(.WIDTH(8), .DEPTH(1)) dutC (
    .clk(clk), .reset(reset), .flush(cFlush), .wr_valid(cWv), .wr_data(cWd),
    .wr_ready(cWr), .rd_valid(cRv), .rd_data(cRd), .rd_ready(cRr),
    .level(cLvl), .stall_cnt(cStall));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] st(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    {aFlush, aWv, aRr, bFlush, bWv, bRr, cFlush, cWv, cRr} = '0;
    aWd = '0; bWd = '0; cWd = '0;
    #1;
    chk("rst_rv", 32'(aRv), 0);
    chk("rst_wr", 32'(aWr), 1);
    chk("rst_lvl", 32'(aLvl), 0);
    chk("rst_rd", 32'(aRd), 0);
    chk("rst_stall", 32'(aStall), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // 1: single word, one-cycle latency, no bypass
    aWv = 1'b1; aWd = 8'h2A;
    #1;
    chk("t1_nobypass", 32'(aRv), 0);
    tick();
    aWv = 1'b0;
    chk("t1_rv", 32'(aRv), 1);
    chk("t1_rd", 32'(aRd), 32'h2A);
    chk("t1_lvl", 32'(aLvl), 1);
    aRr = 1'b1;
    tick();
    aRr = 1'b0;
    chk("t1_pop_lvl", 32'(aLvl), 0);
    chk("t1_pop_rv", 32'(aRv), 0);

    // 2: fill, block third write, pop releases it
    aWv = 1'b1; aWd = 8'h01;
    tick();
    aWd = 8'h02;
    tick();
    chk("t2_full_lvl", 32'(aLvl), 2);
    chk("t2_full_wr", 32'(aWr), 0);
    aWd = 8'h03;
    tick();
    chk("t2_stall1", 32'(aStall), st(1));
    chk("t2_held_lvl", 32'(aLvl), 2);
    tick();
    chk("t2_stall2", 32'(aStall), st(2));
    chk("t2_head01", 32'(aRd), 32'h01);
    aRr = 1'b1;
    tick();
    aRr = 1'b0;
    chk("t2_stall3", 32'(aStall), st(3));
    chk("t2_pop_lvl", 32'(aLvl), 1);
    chk("t2_pop_wr", 32'(aWr), 1);
    tick();
    aWv = 1'b0;
    chk("t2_acc_lvl", 32'(aLvl), 2);
    chk("t2_acc_stall", 32'(aStall), st(3));
    chk("t2_head02", 32'(aRd), 32'h02);
    aRr = 1'b1;
    tick();
    chk("t2_head03", 32'(aRd), 32'h03);
    tick();
    aRr = 1'b0;
    chk("t2_empty", 32'(aLvl), 0);

    // 3: DEPTH=4 streaming at one word per cycle
    bWv = 1'b1; bRr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bWd = 8'(i);
      tick();
      chk("t3_rd", 32'(bRd), 32'(i));
      chk("t3_rv", 32'(bRv), 1);
      chk("t3_lvl", 32'(bLvl), 1);
      chk("t3_wr", 32'(bWr), 1);
    end
    bWv = 1'b0;
    tick();
    bRr = 1'b0;
    chk("t3_drain", 32'(bLvl), 0);

    // 4: DEPTH=1 mailbox alternates accept and block
    cWv = 1'b1; cRr = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cWd = 8'(8'hC0 + j);
      chk("t4_wr_hi", 32'(cWr), 1);
      tick();
      chk("t4_wr_lo", 32'(cWr), 0);
      chk("t4_rd", 32'(cRd), 32'(8'hC0 + j));
      chk("t4_lvl", 32'(cLvl), 1);
      tick();
      chk("t4_rv_lo", 32'(cRv), 0);
    end
    cWv = 1'b0; cRr = 1'b0;

    // 5: flush with a concurrent write
    aWv = 1'b1; aWd = 8'hAA;
    tick();
    aWd = 8'hBB;
    tick();
    chk("t5_full", 32'(aLvl), 2);
    aWd = 8'hCC; aFlush = 1'b1;
    tick();
    aFlush = 1'b0;
    chk("t5_lvl", 32'(aLvl), 0);
    chk("t5_rv", 32'(aRv), 0);
    chk("t5_stall", 32'(aStall), 0);
    chk("t5_wr", 32'(aWr), 1);
    chk("t5_mem_kept", 32'(aRd), 32'hAA);
    aWd = 8'hDD;
    tick();
    aWv = 1'b0;
    chk("t5_after_lvl", 32'(aLvl), 1);
    chk("t5_after_rd", 32'(aRd), 32'hDD);
    aRr = 1'b1;
    tick();
    aRr = 1'b0;

    // 6: asynchronous reset with two words held
    aWv = 1'b1; aWd = 8'h11;
    tick();
    aWd = 8'h22;
    tick();
    aWv = 1'b0;
    chk("t6_full", 32'(aLvl), 2);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_lvl", 32'(aLvl), 0);
    chk("t6_rv", 32'(aRv), 0);
    chk("t6_wr", 32'(aWr), 1);
    chk("t6_rd", 32'(aRd), 0);
    chk("t6_stall", 32'(aStall), 0);
    @(negedge clk);
    reset = 1'b1;
    aWv = 1'b1; aWd = 8'h55;
    tick();
    aWv = 1'b0;
    chk("t6_new_rd", 32'(aRd), 32'h55);
    chk("t6_new_lvl", 32'(aLvl), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
